// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the two-requester I2C/SCCB arbiter:
// FSM state encoding, bus field widths, the captured-request record and
// the default watchdog limit used when IIC_ARB_TIMEOUT_EN is defined.
package iic_arb_pkg;

    localparam int IIC_ADDR_W = 8;
    localparam int IIC_DATA_W = 8;

    // 2 ms at 25 MHz
    localparam logic [15:0] TIMEOUT_CYCLES_DEFAULT = 16'd50000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // One requester's transaction as latched at its start pulse
    typedef struct packed {
        logic                  wr_rd_en;
        logic [IIC_ADDR_W-1:0] addr;
        logic [IIC_DATA_W-1:0] din;
        logic                  iic_main;
    } iic_req_t;

endpackage

// File: rtl/iic_arbiter_if.sv
// Bus bundle between the two config FSMs, the arbiter and the single
// iic_interface byte engine. The slave modport is the arbiter's view;
// the master modport is the view of everything around it.
interface iic_arbiter_if;
    import iic_arb_pkg::*;

    // requester 0 (ADV7511 HDMI configurator)
    logic                  i_req0_start;
    logic                  i_req0_wr_rd_en;
    logic [IIC_ADDR_W-1:0] i_req0_addr;
    logic [IIC_DATA_W-1:0] i_req0_din;
    logic                  i_req0_iic_main;
    logic                  o_req0_busy;
    logic                  o_req0_finish;
    logic                  o_req0_no_ack;
    logic                  o_req0_dout_en;
    logic [IIC_DATA_W-1:0] o_req0_dout;

    // requester 1 (OV7670 SCCB configurator)
    logic                  i_req1_start;
    logic                  i_req1_wr_rd_en;
    logic [IIC_ADDR_W-1:0] i_req1_addr;
    logic [IIC_DATA_W-1:0] i_req1_din;
    logic                  i_req1_iic_main;
    logic                  o_req1_busy;
    logic                  o_req1_finish;
    logic                  o_req1_no_ack;
    logic                  o_req1_dout_en;
    logic [IIC_DATA_W-1:0] o_req1_dout;

    // shared byte engine
    logic                  o_start;
    logic                  o_wr_rd_en;
    logic [IIC_ADDR_W-1:0] o_addr;
    logic [IIC_DATA_W-1:0] o_din;
    logic                  o_iic_main;
    logic                  i_finish;
    logic                  i_no_ack;
    logic                  i_dout_en;
    logic [IIC_DATA_W-1:0] i_dout;

    // ownership status
    logic                  o_grant;
    logic                  o_active;

    modport slave (
        input  i_req0_start, i_req0_wr_rd_en, i_req0_addr, i_req0_din, i_req0_iic_main,
        output o_req0_busy, o_req0_finish, o_req0_no_ack, o_req0_dout_en, o_req0_dout,
        input  i_req1_start, i_req1_wr_rd_en, i_req1_addr, i_req1_din, i_req1_iic_main,
        output o_req1_busy, o_req1_finish, o_req1_no_ack, o_req1_dout_en, o_req1_dout,
        output o_start, o_wr_rd_en, o_addr, o_din, o_iic_main,
        input  i_finish, i_no_ack, i_dout_en, i_dout,
        output o_grant, o_active
    );

    modport master (
        output i_req0_start, i_req0_wr_rd_en, i_req0_addr, i_req0_din, i_req0_iic_main,
        input  o_req0_busy, o_req0_finish, o_req0_no_ack, o_req0_dout_en, o_req0_dout,
        output i_req1_start, i_req1_wr_rd_en, i_req1_addr, i_req1_din, i_req1_iic_main,
        input  o_req1_busy, o_req1_finish, o_req1_no_ack, o_req1_dout_en, o_req1_dout,
        input  o_start, o_wr_rd_en, o_addr, o_din, o_iic_main,
        output i_finish, i_no_ack, i_dout_en, i_dout,
        input  o_grant, o_active
    );

endinterface

// File: rtl/iic_req_latch.sv
// Per-requester capture stage: a start pulse while idle latches the
// transaction fields and raises pending; pending stays up (and further
// starts are ignored) until the arbiter clears it at the end of DONE.
module iic_req_latch
    import iic_arb_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     start,
    input  iic_req_t req_in,
    input  logic     clear,
    output logic     pending,
    output iic_req_t req
);

    logic     pending_reg;
    iic_req_t req_reg;

    // capture on start when idle; clear wins so a start in the finish cycle is dropped
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pending_reg <= 1'b0;
            req_reg     <= '0;
        end else if (clear) begin
            pending_reg <= 1'b0;
        end else if (start && !pending_reg) begin
            pending_reg <= 1'b1;
            req_reg     <= req_in;
        end
    end

    assign pending = pending_reg;
    assign req     = req_reg;

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one iic_interface byte engine between the
// ADV7511 (requester 0) and OV7670 (requester 1) configurators.
// IDLE picks an owner, ISSUE pulses o_start, WAIT holds the owner's
// fields until the engine finishes, DONE returns finish/no-ack to the
// owner and gives the bus one turnaround cycle.
// Optional watchdog: define IIC_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles, reported to the owner as finish with no-ack.
module iic_arbiter
    import iic_arb_pkg::*;
`ifdef IIC_ARB_TIMEOUT_EN
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
    input  logic         i_clk,
    input  logic         i_rst,
    iic_arbiter_if.slave bus
);

    arb_state_t state_reg, state_next;
    logic       grant_reg, grant_next;
    logic       last_grant_reg, last_grant_next;
    logic       no_ack_reg, no_ack_next;
    logic       timeout_hit;

    logic [1:0] req_start;
    iic_req_t   req_in   [2];
    iic_req_t   req_held [2];
    logic [1:0] pending;
    logic [1:0] clear;

    logic [1:0]                 finish;
    logic [1:0]                 no_ack;
    logic [1:0]                 dout_en;
    logic [1:0][IIC_DATA_W-1:0] dout;

    iic_req_t owner;
    logic     active;

    assign req_start = {bus.i_req1_start, bus.i_req0_start};
    assign req_in[0] = '{wr_rd_en: bus.i_req0_wr_rd_en, addr: bus.i_req0_addr,
                         din: bus.i_req0_din, iic_main: bus.i_req0_iic_main};
    assign req_in[1] = '{wr_rd_en: bus.i_req1_wr_rd_en, addr: bus.i_req1_addr,
                         din: bus.i_req1_din, iic_main: bus.i_req1_iic_main};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic                  owns;
        logic                  fwd;
        logic                  dout_en_reg;
        logic [IIC_DATA_W-1:0] dout_reg;

        assign owns = (grant_reg == 1'(gi));
        assign fwd  = (state_reg == ST_WAIT) && owns && bus.i_dout_en;

        iic_req_latch u_latch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .start   (req_start[gi]),
            .req_in  (req_in[gi]),
            .clear   (clear[gi]),
            .pending (pending[gi]),
            .req     (req_held[gi])
        );

        // read data goes back one cycle late, and only to the live owner
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                dout_en_reg <= 1'b0;
                dout_reg    <= '0;
            end else begin
                dout_en_reg <= fwd;
                if (fwd) begin
                    dout_reg <= bus.i_dout;
                end
            end
        end

        assign finish[gi]  = (state_reg == ST_DONE) && owns;
        assign no_ack[gi]  = finish[gi] && no_ack_reg;
        assign dout_en[gi] = dout_en_reg;
        assign dout[gi]    = dout_reg;
    end

`ifdef IIC_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt_reg;

    // watchdog: restart at ISSUE, count every WAIT cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == ST_ISSUE) begin
            wd_cnt_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
        end
    end

    assign timeout_hit = (state_reg == ST_WAIT) && (wd_cnt_reg == TIMEOUT_CYCLES - 16'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    // FSM and ownership registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;   // so channel 0 wins the first tie
            no_ack_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            no_ack_reg     <= no_ack_next;
        end
    end

    // next-state, owner selection and pending release
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        no_ack_next     = no_ack_reg;
        clear           = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (|pending) begin
                    // on a tie the channel not served last goes first
                    if (&pending) begin
                        grant_next = ~last_grant_reg;
                    end else begin
                        grant_next = pending[1];
                    end
                    last_grant_next = grant_next;
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_finish) begin
                    no_ack_next = bus.i_no_ack;
                    state_next  = ST_DONE;
                end else if (timeout_hit) begin
                    no_ack_next = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                clear[grant_reg] = 1'b1;
                state_next       = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign owner  = req_held[grant_reg];
    assign active = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);

    assign bus.o_start    = (state_reg == ST_ISSUE);
    assign bus.o_wr_rd_en = active && owner.wr_rd_en;
    assign bus.o_addr     = active ? owner.addr : '0;
    assign bus.o_din      = active ? owner.din  : '0;
    assign bus.o_iic_main = active && owner.iic_main;
    assign bus.o_grant    = grant_reg;
    assign bus.o_active   = active;

    assign bus.o_req0_busy    = pending[0];
    assign bus.o_req0_finish  = finish[0];
    assign bus.o_req0_no_ack  = no_ack[0];
    assign bus.o_req0_dout_en = dout_en[0];
    assign bus.o_req0_dout    = dout[0];

    assign bus.o_req1_busy    = pending[1];
    assign bus.o_req1_finish  = finish[1];
    assign bus.o_req1_no_ack  = no_ack[1];
    assign bus.o_req1_dout_en = dout_en[1];
    assign bus.o_req1_dout    = dout[1];

endmodule

// File: tb/tb_iic_arbiter.sv
// Bench for iic_arbiter: a per-cycle vector table (inputs applied just
// after a rising edge, outputs compared on the following falling edge)
// covering ties, routing, no-ack and restart-while-busy, then hand-written
// sequences for the long single write, busy restart with mid-transaction
// reset, and (with IIC_ARB_TIMEOUT_EN) the watchdog.
module tb_iic_arbiter;
    import iic_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iic_arbiter_if bus ();

`ifdef IIC_ARB_TIMEOUT_EN
    iic_arbiter #(.TIMEOUT_CYCLES(16'd20)) dut (.i_clk(clk), .i_rst(rst_n), .bus(bus.slave));
`else
    iic_arbiter dut (.i_clk(clk), .i_rst(rst_n), .bus(bus.slave));
`endif

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic s0, input logic s1, input logic fin, input logic nack,
                         input logic den, input logic [7:0] dat);
        bus.i_req0_start = s0;
        bus.i_req1_start = s1;
        bus.i_finish     = fin;
        bus.i_no_ack     = nack;
        bus.i_dout_en    = den;
        bus.i_dout       = dat;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 8'h00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic s0, s1, fin, nack, den; logic [7:0] dat;
        logic start, act, grant; logic [7:0] addr; logic wr;
        logic b0, b1, f0, f1, n0, n1, d0, d1; logic [7:0] dout0, dout1;
    } vec_t;

    // columns: s0 s1 fin nack den dat | start act grant addr wr b0 b1 f0 f1 n0 n1 d0 d1 dout0 dout1
    vec_t vecs [27];

    int f0_cnt, f1_cnt, st_cnt, other_cnt, f0_at, n0_at;

    initial begin
        vecs = '{
            '{1,1,0,0,0,8'h00, 0,0,0,8'h00,0, 0,0,0,0,0,0,0,0, 8'h00,8'h00}, // r0 tie
            '{0,0,0,0,0,8'h00, 0,0,0,8'h00,0, 1,1,0,0,0,0,0,0, 8'h00,8'h00}, // r1 both pending
            '{0,0,0,0,0,8'h00, 1,1,0,8'h41,0, 1,1,0,0,0,0,0,0, 8'h00,8'h00}, // r2 ch0 issue
            '{0,0,1,1,0,8'h00, 0,1,0,8'h41,0, 1,1,0,0,0,0,0,0, 8'h00,8'h00}, // r3 finish+nack
            '{1,0,0,0,0,8'h00, 0,0,0,8'h00,0, 1,1,1,0,1,0,0,0, 8'h00,8'h00}, // r4 done, restart ignored
            '{0,0,0,0,0,8'h00, 0,0,0,8'h00,0, 0,1,0,0,0,0,0,0, 8'h00,8'h00}, // r5 idle
            '{0,0,0,0,0,8'h00, 1,1,1,8'h42,1, 0,1,0,0,0,0,0,0, 8'h00,8'h00}, // r6 ch1 issue
            '{0,0,0,0,1,8'h76, 0,1,1,8'h42,1, 0,1,0,0,0,0,0,0, 8'h00,8'h00}, // r7 read data
            '{0,0,0,0,0,8'h00, 0,1,1,8'h42,1, 0,1,0,0,0,0,0,1, 8'h00,8'h76}, // r8 forwarded
            '{0,0,1,0,0,8'h00, 0,1,1,8'h42,1, 0,1,0,0,0,0,0,0, 8'h00,8'h76}, // r9 finish
            '{0,1,0,0,0,8'h00, 0,0,1,8'h00,0, 0,1,0,1,0,0,0,0, 8'h00,8'h76}, // r10 done, restart ignored
            '{1,0,0,0,0,8'h00, 0,0,1,8'h00,0, 0,0,0,0,0,0,0,0, 8'h00,8'h76}, // r11 ch0 solo start
            '{0,0,0,0,0,8'h00, 0,0,1,8'h00,0, 1,0,0,0,0,0,0,0, 8'h00,8'h76}, // r12
            '{0,0,0,0,0,8'h00, 1,1,0,8'h41,0, 1,0,0,0,0,0,0,0, 8'h00,8'h76}, // r13
            '{0,0,1,0,1,8'h33, 0,1,0,8'h41,0, 1,0,0,0,0,0,0,0, 8'h00,8'h76}, // r14 finish+data
            '{0,0,0,0,1,8'h99, 0,0,0,8'h00,0, 1,0,1,0,0,0,1,0, 8'h33,8'h76}, // r15 stray data
            '{1,1,0,0,0,8'h00, 0,0,0,8'h00,0, 0,0,0,0,0,0,0,0, 8'h33,8'h76}, // r16 second tie
            '{0,0,0,0,0,8'h00, 0,0,0,8'h00,0, 1,1,0,0,0,0,0,0, 8'h33,8'h76}, // r17
            '{0,0,0,0,0,8'h00, 1,1,1,8'h42,1, 1,1,0,0,0,0,0,0, 8'h33,8'h76}, // r18 ch1 wins
            '{0,0,1,0,0,8'h00, 0,1,1,8'h42,1, 1,1,0,0,0,0,0,0, 8'h33,8'h76}, // r19
            '{0,0,0,0,0,8'h00, 0,0,1,8'h00,0, 1,1,0,1,0,0,0,0, 8'h33,8'h76}, // r20
            '{0,0,0,0,0,8'h00, 0,0,1,8'h00,0, 1,0,0,0,0,0,0,0, 8'h33,8'h76}, // r21
            '{0,0,0,0,0,8'h00, 1,1,0,8'h41,0, 1,0,0,0,0,0,0,0, 8'h33,8'h76}, // r22
            '{0,0,1,0,0,8'h00, 0,1,0,8'h41,0, 1,0,0,0,0,0,0,0, 8'h33,8'h76}, // r23
            '{0,0,0,0,0,8'h00, 0,0,0,8'h00,0, 1,0,1,0,0,0,0,0, 8'h33,8'h76}, // r24
            '{0,0,1,0,0,8'h00, 0,0,0,8'h00,0, 0,0,0,0,0,0,0,0, 8'h33,8'h76}, // r25 stray finish
            '{0,0,0,0,0,8'h00, 0,0,0,8'h00,0, 0,0,0,0,0,0,0,0, 8'h33,8'h76}  // r26
        };

        bus.i_req0_wr_rd_en = 1'b0; bus.i_req0_addr = 8'h41; bus.i_req0_din = 8'h10; bus.i_req0_iic_main = 1'b1;
        bus.i_req1_wr_rd_en = 1'b1; bus.i_req1_addr = 8'h42; bus.i_req1_din = 8'h55; bus.i_req1_iic_main = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00);

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst start",  bus.o_start, 0);
        check("rst active", bus.o_active, 0);
        check("rst grant",  bus.o_grant, 0);
        check("rst addr",   bus.o_addr, 0);
        check("rst busy",   {bus.o_req0_busy, bus.o_req1_busy}, 0);
        check("rst finish", {bus.o_req0_finish, bus.o_req1_finish, bus.o_req0_no_ack, bus.o_req1_no_ack}, 0);
        check("rst dout",   {bus.o_req0_dout_en, bus.o_req1_dout_en, bus.o_req0_dout, bus.o_req1_dout}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // table-driven cycles
        for (int i = 0; i < 27; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].s0, vecs[i].s1, vecs[i].fin, vecs[i].nack, vecs[i].den, vecs[i].dat);
            @(negedge clk);
            check($sformatf("r%0d start", i),  bus.o_start,        vecs[i].start);
            check($sformatf("r%0d active", i), bus.o_active,       vecs[i].act);
            check($sformatf("r%0d grant", i),  bus.o_grant,        vecs[i].grant);
            check($sformatf("r%0d addr", i),   bus.o_addr,         vecs[i].addr);
            check($sformatf("r%0d wr", i),     bus.o_wr_rd_en,     vecs[i].wr);
            check($sformatf("r%0d busy0", i),  bus.o_req0_busy,    vecs[i].b0);
            check($sformatf("r%0d busy1", i),  bus.o_req1_busy,    vecs[i].b1);
            check($sformatf("r%0d fin0", i),   bus.o_req0_finish,  vecs[i].f0);
            check($sformatf("r%0d fin1", i),   bus.o_req1_finish,  vecs[i].f1);
            check($sformatf("r%0d nack0", i),  bus.o_req0_no_ack,  vecs[i].n0);
            check($sformatf("r%0d nack1", i),  bus.o_req1_no_ack,  vecs[i].n1);
            check($sformatf("r%0d den0", i),   bus.o_req0_dout_en, vecs[i].d0);
            check($sformatf("r%0d den1", i),   bus.o_req1_dout_en, vecs[i].d1);
            check($sformatf("r%0d dout0", i),  bus.o_req0_dout,    vecs[i].dout0);
            check($sformatf("r%0d dout1", i),  bus.o_req1_dout,    vecs[i].dout1);
        end

        // single write, engine finishes 100 cycles after the request
        do_reset();
        f0_cnt = 0; st_cnt = 0; other_cnt = 0; f0_at = -1;
        for (int i = 0; i <= 104; i++) begin
            @(posedge clk); #1;
            drive(i == 0, 0, i == 100, 0, 0, 8'h00);
            @(negedge clk);
            if (i == 1) check("wr start early", bus.o_start, 0);
            if (i == 2) begin
                check("wr start", bus.o_start, 1);
                check("wr addr",  bus.o_addr, 8'h41);
                check("wr din",   bus.o_din, 8'h10);
                check("wr main",  bus.o_iic_main, 1);
            end
            if (bus.o_start) st_cnt++;
            if (bus.o_req0_finish) begin f0_cnt++; f0_at = i; end
            if (bus.o_req1_busy || bus.o_req1_finish || bus.o_req1_no_ack || bus.o_req1_dout_en) other_cnt++;
        end
        check("wr start count",  st_cnt, 1);
        check("wr finish count", f0_cnt, 1);
        check("wr finish cycle", 16'(f0_at), 101);
        check("wr req1 quiet",   other_cnt, 0);

        // restart while busy is ignored, then reset in WAIT
        do_reset();
        st_cnt = 0;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            drive(i == 0 || i == 5, 0, 0, 0, 0, 8'h00);
            bus.i_req0_addr = (i == 5) ? 8'h99 : 8'h41;
            @(negedge clk);
            if (bus.o_start) st_cnt++;
            if (i == 8) check("busy addr held", bus.o_addr, 8'h41);
        end
        bus.i_req0_addr = 8'h41;
        check("busy start count", st_cnt, 1);
        check("busy still active", bus.o_active, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid rst active", bus.o_active, 0);
        check("mid rst busy0",  bus.o_req0_busy, 0);
        f0_cnt = 0; st_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.o_req0_finish) f0_cnt++;
            if (bus.o_start) st_cnt++;
        end
        check("mid rst no finish", f0_cnt, 0);
        check("mid rst no start",  st_cnt, 0);

`ifdef IIC_ARB_TIMEOUT_EN
        // watchdog: WAIT entered at i=3, abort reported at i=23, late finish at i=26
        do_reset();
        f0_cnt = 0; f0_at = -1; n0_at = -1;
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk); #1;
            drive(i == 0, 0, i == 26, 0, 0, 8'h00);
            @(negedge clk);
            if (bus.o_req0_finish) begin f0_cnt++; f0_at = i; end
            if (bus.o_req0_no_ack) n0_at = i;
        end
        check("to finish cycle", 16'(f0_at), 23);
        check("to nack cycle",   16'(n0_at), 23);
        check("to finish count", f0_cnt, 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
